// File: rtl/fir_par2ser.sv
// fir_par2ser: frame FIFO that serialises LANES-wide FIR output frames
// into a single valid/ready sample stream, oldest lane first.
// Ports: CLK, RST_N (async, active-low), VIN/DIN frame input (no
// backpressure), DOUT/VOUT/OUT_RDY sample output, LEVEL stored frames,
// OVF sticky overflow, CLR_OVF clear. Defining FIR_P2S_DROPCNT_EN adds
// DROP_CNT, a saturating count of discarded frames.
module fir_par2ser #(
   parameter int NB    = 8,
   parameter int LANES = 3,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       VIN,
   input  logic [LANES*NB-1:0]        DIN,
   output logic [NB-1:0]              DOUT,
   output logic                       VOUT,
   input  logic                       OUT_RDY,
   output logic [$clog2(DEPTH+1)-1:0] LEVEL,
   output logic                       OVF,
`ifdef FIR_P2S_DROPCNT_EN
   output logic [7:0]                 DROP_CNT,
`endif
   input  logic                       CLR_OVF
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

   logic [LANES*NB-1:0] mem_q [DEPTH];
   logic [AW-1:0]       wptr_q, wptr_d;
   logic [AW-1:0]       rptr_q, rptr_d;
   logic [IW-1:0]       lidx_q, lidx_d;
   logic [LW-1:0]       level_q, level_d;
   logic                ovf_q, ovf_d;
   logic                full, xfer, last;
   logic                pop, push, ovf_ev;
   logic [LANES*NB-1:0] head;
   logic [NB-1:0]       dout;

   // A pop frees the slot in the same cycle, so a push at full is
   // still accepted when the last lane of the head frame leaves.
   always_comb begin
      full   = (level_q == LW'(DEPTH));
      xfer   = VOUT & OUT_RDY;
      last   = (lidx_q == IW'(LANES-1));
      pop    = xfer & last;
      push   = VIN & (~full | pop);
      ovf_ev = VIN & full & ~pop;
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      lidx_d  = lidx_q;
      level_d = level_q;
      ovf_d   = ovf_q;
      if (push) wptr_d = wptr_q + AW'(1);
      if (xfer) begin
         if (last) begin
            lidx_d = '0;
            rptr_d = rptr_q + AW'(1);
         end else begin
            lidx_d = lidx_q + IW'(1);
         end
      end
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      // A new overflow beats a clear in the same cycle.
      if (ovf_ev)       ovf_d = 1'b1;
      else if (CLR_OVF) ovf_d = 1'b0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         lidx_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         lidx_q  <= lidx_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wptr_q] <= DIN;
      end
   end

   // Output lane is decoded straight from storage, so it reads zero
   // under reset and holds while the consumer stalls.
   always_comb begin
      head = mem_q[rptr_q];
      dout = '0;
      for (int i = 0; i < LANES; i++) begin
         if (lidx_q == IW'(i)) dout = head[i*NB +: NB];
      end
   end

   assign DOUT  = dout;
   assign VOUT  = (level_q != '0);
   assign LEVEL = level_q;
   assign OVF   = ovf_q;

`ifdef FIR_P2S_DROPCNT_EN
   logic [7:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (ovf_ev) begin
         if (CLR_OVF)             drop_d = 8'd1;
         else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else if (CLR_OVF) begin
         drop_d = 8'd0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) drop_q <= 8'd0;
      else        drop_q <= drop_d;
   end

   assign DROP_CNT = drop_q;
`endif

endmodule

// File: tb/tb_fir_par2ser.sv
// tb_fir_par2ser: randomized and directed bench for fir_par2ser with a
// sample-queue reference model.
module tb_fir_par2ser;

   localparam int NB    = 8;
   localparam int LANES = 3;
   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        VIN = 1'b0;
   logic [23:0] DIN = '0;
   logic        OUT_RDY = 1'b0;
   logic        CLR_OVF = 1'b0;
   logic [7:0]  DOUT;
   logic        VOUT;
   logic [2:0]  LEVEL;
   logic        OVF;
`ifdef FIR_P2S_DROPCNT_EN
   logic [7:0]  DROP_CNT;
`endif

   fir_par2ser #(.NB(NB), .LANES(LANES), .DEPTH(DEPTH)) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .VIN(VIN),
      .DIN(DIN),
      .DOUT(DOUT),
      .VOUT(VOUT),
      .OUT_RDY(OUT_RDY),
      .LEVEL(LEVEL),
      .OVF(OVF),
`ifdef FIR_P2S_DROPCNT_EN
      .DROP_CNT(DROP_CNT),
`endif
      .CLR_OVF(CLR_OVF)
   );

   always #5 CLK = ~CLK;

   int nchk = 0;
   int nfail = 0;

   // Reference: pending samples in time order, plus sticky flags.
   logic [7:0] sq[$];
   bit         m_ovf = 1'b0;
   int         m_drop = 0;

   function automatic int mlevel();
      return (sq.size() + LANES - 1) / LANES;
   endfunction

   function automatic logic [23:0] frm(input int b);
      logic [7:0] l0, l1, l2;
      l0 = 8'(b);
      l1 = 8'(b + 1);
      l2 = 8'(b + 2);
      return {l2, l1, l0};
   endfunction

   task automatic step(input bit vin, input logic [23:0] din,
                       input bit rdy, input bit clr);
      bit xfer, popm, push, ev;
      int lv;
      VIN = vin; DIN = din; OUT_RDY = rdy; CLR_OVF = clr;
      lv   = mlevel();
      xfer = (sq.size() != 0) && rdy;
      popm = xfer && (sq.size() % LANES == 1);
      push = vin && (lv < DEPTH || popm);
      ev   = vin && (lv == DEPTH) && !popm;
      @(posedge CLK);
      if (xfer) void'(sq.pop_front());
      if (push)
         for (int i = 0; i < LANES; i++) sq.push_back(din[i*NB +: NB]);
      if (ev) begin
         m_ovf  = 1'b1;
         m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      end else if (clr) begin
         m_ovf  = 1'b0;
         m_drop = 0;
      end
      @(negedge CLK);
      VIN = 1'b0;
      CLR_OVF = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      nchk++;
      if (VOUT !== 1'b0 || DOUT !== 8'h00 || LEVEL !== 3'd0 || OVF !== 1'b0) begin
         nfail++;
         $display("FAIL reset_hold got v=%b d=%h l=%0d o=%b exp all 0", VOUT, DOUT, LEVEL, OVF);
      end
`ifdef FIR_P2S_DROPCNT_EN
      nchk++;
      if (DROP_CNT !== 8'd0) begin
         nfail++;
         $display("FAIL reset_drop got %0d exp 0", DROP_CNT);
      end
`endif
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
      nchk++;
      if (VOUT !== 1'b0 || DOUT !== 8'h00 || LEVEL !== 3'd0 || OVF !== 1'b0) begin
         nfail++;
         $display("FAIL reset_release got v=%b d=%h l=%0d o=%b exp all 0", VOUT, DOUT, LEVEL, OVF);
      end
      @(negedge CLK);
   endtask

   task automatic test_single();
      logic [7:0] ed;
      step(1'b1, frm(1), 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         ed = 8'(k + 1);
         nchk++;
         if (VOUT !== (k < 3) || LEVEL !== ((k < 3) ? 3'd1 : 3'd0)) begin
            nfail++;
            $display("FAIL single_vl k=%0d got v=%b l=%0d exp v=%b", k, VOUT, LEVEL, k < 3);
         end
         if (k < 3) begin
            nchk++;
            if (DOUT !== ed) begin
               nfail++;
               $display("FAIL single_dout k=%0d got %h exp %h", k, DOUT, ed);
            end
         end
         step(1'b0, '0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] ed;
      step(1'b1, frm(1), 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         nchk++;
         if (VOUT !== 1'b1 || DOUT !== 8'h01) begin
            nfail++;
            $display("FAIL bp_hold k=%0d got v=%b d=%h exp 1 01", k, VOUT, DOUT);
         end
         step(1'b0, '0, 1'b0, 1'b0);
      end
      for (int k = 0; k < 3; k++) begin
         ed = 8'(k + 1);
         nchk++;
         if (VOUT !== 1'b1 || DOUT !== ed) begin
            nfail++;
            $display("FAIL bp_drain k=%0d got v=%b d=%h exp 1 %h", k, VOUT, DOUT, ed);
         end
         step(1'b0, '0, 1'b1, 1'b0);
      end
      nchk++;
      if (VOUT !== 1'b0) begin
         nfail++;
         $display("FAIL bp_end got v=%b exp 0", VOUT);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] ed;
      for (int f = 0; f < 5; f++) step(1'b1, frm(16 * (f + 1)), 1'b0, 1'b0);
      nchk++;
      if (LEVEL !== 3'd4 || OVF !== 1'b1) begin
         nfail++;
         $display("FAIL ovf_state got l=%0d o=%b exp 4 1", LEVEL, OVF);
      end
`ifdef FIR_P2S_DROPCNT_EN
      nchk++;
      if (DROP_CNT !== 8'd1) begin
         nfail++;
         $display("FAIL ovf_drop got %0d exp 1", DROP_CNT);
      end
`endif
      for (int j = 0; j < 12; j++) begin
         ed = 8'((j / 3 + 1) * 16 + j % 3);
         nchk++;
         if (VOUT !== 1'b1 || DOUT !== ed) begin
            nfail++;
            $display("FAIL ovf_drain j=%0d got v=%b d=%h exp 1 %h", j, VOUT, DOUT, ed);
         end
         step(1'b0, '0, 1'b1, 1'b0);
      end
      nchk++;
      if (VOUT !== 1'b0 || OVF !== 1'b1) begin
         nfail++;
         $display("FAIL ovf_sticky got v=%b o=%b exp 0 1", VOUT, OVF);
      end
      step(1'b0, '0, 1'b0, 1'b1);
      nchk++;
      if (OVF !== 1'b0) begin
         nfail++;
         $display("FAIL ovf_clr got %b exp 0", OVF);
      end
`ifdef FIR_P2S_DROPCNT_EN
      nchk++;
      if (DROP_CNT !== 8'd0) begin
         nfail++;
         $display("FAIL ovf_clr_drop got %0d exp 0", DROP_CNT);
      end
`endif
   endtask

   task automatic test_full_pushpop();
      logic [23:0] newf;
      int guard;
      for (int f = 0; f < 4; f++) step(1'b1, 24'($urandom), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      nchk++;
      if (LEVEL !== 3'd4) begin
         nfail++;
         $display("FAIL fpp_pre got l=%0d exp 4", LEVEL);
      end
      newf = 24'($urandom);
      step(1'b1, newf, 1'b1, 1'b0);
      nchk++;
      if (LEVEL !== 3'd4 || OVF !== 1'b0) begin
         nfail++;
         $display("FAIL fpp_post got l=%0d o=%b exp 4 0", LEVEL, OVF);
      end
      guard = 0;
      while (sq.size() != 0 && guard < 20) begin
         nchk++;
         if (VOUT !== 1'b1 || DOUT !== sq[0]) begin
            nfail++;
            $display("FAIL fpp_drain got v=%b d=%h exp 1 %h", VOUT, DOUT, sq[0]);
         end
         if (sq.size() <= 3) begin
            nchk++;
            if (DOUT !== newf[(3 - sq.size())*8 +: 8]) begin
               nfail++;
               $display("FAIL fpp_last got %h exp %h", DOUT, newf[(3 - sq.size())*8 +: 8]);
            end
         end
         step(1'b0, '0, 1'b1, 1'b0);
         guard++;
      end
      nchk++;
      if (VOUT !== 1'b0 || sq.size() != 0) begin
         nfail++;
         $display("FAIL fpp_end got v=%b pending=%0d exp 0 0", VOUT, sq.size());
      end
   endtask

   task automatic test_clr_collision();
      for (int f = 0; f < 4; f++) step(1'b1, 24'($urandom), 1'b0, 1'b0);
      step(1'b1, 24'($urandom), 1'b0, 1'b1);
      nchk++;
      if (OVF !== 1'b1 || LEVEL !== 3'd4) begin
         nfail++;
         $display("FAIL coll_set got o=%b l=%0d exp 1 4", OVF, LEVEL);
      end
`ifdef FIR_P2S_DROPCNT_EN
      nchk++;
      if (DROP_CNT !== 8'd1) begin
         nfail++;
         $display("FAIL coll_drop got %0d exp 1", DROP_CNT);
      end
      for (int k = 0; k < 300; k++) step(1'b1, 24'($urandom), 1'b0, 1'b0);
      nchk++;
      if (DROP_CNT !== 8'(m_drop) || DROP_CNT !== 8'd255) begin
         nfail++;
         $display("FAIL drop_sat got %0d exp 255", DROP_CNT);
      end
`endif
      step(1'b0, '0, 1'b0, 1'b1);
      nchk++;
      if (OVF !== 1'b0) begin
         nfail++;
         $display("FAIL coll_clr got %b exp 0", OVF);
      end
      for (int j = 0; j < 12; j++) begin
         nchk++;
         if (VOUT !== 1'b1 || DOUT !== sq[0]) begin
            nfail++;
            $display("FAIL coll_drain j=%0d got v=%b d=%h exp 1 %h", j, VOUT, DOUT, sq[0]);
         end
         step(1'b0, '0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_stream();
      for (int i = 0; i <= 300; i++) begin
         nchk++;
         if (VOUT !== (i >= 1) || LEVEL > 3'd1 || OVF !== 1'b0) begin
            nfail++;
            $display("FAIL stream_ctl i=%0d got v=%b l=%0d o=%b", i, VOUT, LEVEL, OVF);
         end
         if (sq.size() != 0) begin
            nchk++;
            if (DOUT !== sq[0]) begin
               nfail++;
               $display("FAIL stream_dout i=%0d got %h exp %h", i, DOUT, sq[0]);
            end
         end
         step(i < 300 && i % 3 == 0, 24'($urandom), 1'b1, 1'b0);
      end
      nchk++;
      if (VOUT !== 1'b0 || sq.size() != 0) begin
         nfail++;
         $display("FAIL stream_end got v=%b pending=%0d exp 0 0", VOUT, sq.size());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 520; i++) begin
         nchk++;
         if (VOUT !== (sq.size() != 0) || LEVEL !== 3'(mlevel()) || OVF !== m_ovf) begin
            nfail++;
            $display("FAIL rand_ctl i=%0d got v=%b l=%0d o=%b exp %b %0d %b",
                     i, VOUT, LEVEL, OVF, sq.size() != 0, mlevel(), m_ovf);
         end
         if (sq.size() != 0) begin
            nchk++;
            if (DOUT !== sq[0]) begin
               nfail++;
               $display("FAIL rand_dout i=%0d got %h exp %h", i, DOUT, sq[0]);
            end
         end
`ifdef FIR_P2S_DROPCNT_EN
         nchk++;
         if (DROP_CNT !== 8'(m_drop)) begin
            nfail++;
            $display("FAIL rand_drop i=%0d got %0d exp %0d", i, DROP_CNT, m_drop);
         end
`endif
         if (i < 500)
            step($urandom_range(0, 3) == 0, 24'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
         else
            step(1'b0, '0, 1'b1, 1'b1);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 24'hC3B2A1, 1'b1, 1'b0);
      nchk++;
      if (DOUT !== 8'hA1) begin
         nfail++;
         $display("FAIL rm_lane0 got %h exp a1", DOUT);
      end
      step(1'b1, 24'hF3E2D1, 1'b1, 1'b0);
      nchk++;
      if (DOUT !== 8'hB2 || LEVEL !== 3'd2) begin
         nfail++;
         $display("FAIL rm_lane1 got d=%h l=%0d exp b2 2", DOUT, LEVEL);
      end
      #2;
      RST_N = 1'b0;
      #1;
      nchk++;
      if (VOUT !== 1'b0 || DOUT !== 8'h00 || LEVEL !== 3'd0 || OVF !== 1'b0) begin
         nfail++;
         $display("FAIL rm_async got v=%b d=%h l=%0d o=%b exp all 0", VOUT, DOUT, LEVEL, OVF);
      end
      sq.delete();
      m_ovf = 1'b0;
      m_drop = 0;
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      nchk++;
      if (VOUT !== 1'b0) begin
         nfail++;
         $display("FAIL rm_release got v=%b exp 0", VOUT);
      end
      step(1'b1, 24'h665544, 1'b0, 1'b0);
      nchk++;
      if (VOUT !== 1'b1 || DOUT !== 8'h44 || LEVEL !== 3'd1) begin
         nfail++;
         $display("FAIL rm_new got v=%b d=%h l=%0d exp 1 44 1", VOUT, DOUT, LEVEL);
      end
      for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_overflow();
      test_full_pushpop();
      test_clr_collision();
      test_stream();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/fir_par2ser.md
# fir_par2ser

Frame-buffered parallel-to-serial converter for the J-parallel (unfolded) FIR datapath. It accepts one frame of `LANES` output samples per valid cycle, in the order 3k, 3k+1, 3k+2 for `LANES=3`. Frames are stored in a `DEPTH`-frame FIFO. Samples leave one per cycle in time order on a single valid/ready stream. The block sits between the parallel `Fir` outputs and any single-rate consumer (result writer, DAC model, checker).

## Interface
- `NB`, 8: sample width in bits.
- `LANES`, 3: samples per input frame; ≥ 2.
- `DEPTH`, 4: frame FIFO depth; power of 2, ≥ 2.
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `VIN` in 1: input frame valid. There is no input backpressure.
- `DIN` in `LANES*NB`: frame. Lane i occupies bits `[i*NB +: NB]`; lane 0 is the oldest sample (3k).
- `DOUT` out `NB`: current output sample.
- `VOUT` out 1: `DOUT` is valid.
- `OUT_RDY` in 1: consumer accepts `DOUT` this cycle.
- `LEVEL` out `$clog2(DEPTH+1)`: number of frames stored, including the partially emitted frame.
- `OVF` out 1: sticky overflow flag.
- `CLR_OVF` in 1: synchronous clear of `OVF`.
- `DROP_CNT` out 8: dropped-frame counter. Present only with `FIR_P2S_DROPCNT_EN`.

## Operation
- Storage: `DEPTH` x `LANES` x `NB` register array, a write pointer, a read pointer (log2 `DEPTH` bits each, wrapping naturally) and a lane index `lidx` in 0..`LANES-1`.
- Push: when `VIN`=1 and the FIFO is not full (or a pop occurs in the same cycle), write `DIN` at the write pointer, then increment the write pointer.
- Output: `VOUT` = (`LEVEL` != 0). `DOUT` = lane `lidx` of the frame at the read pointer.
- Transfer: a transfer occurs when `VOUT` & `OUT_RDY`.
  - On a transfer with `lidx` < `LANES-1`: `lidx` increments.
  - On a transfer with `lidx` = `LANES-1`: pop. `lidx` returns to 0 and the read pointer increments.
- `LEVEL` update: next = `LEVEL` + push − pop.
- Overflow: `VIN`=1 while `LEVEL`=`DEPTH` and no pop this cycle.
  - The frame is discarded.
  - `OVF` is set to 1.
  - Stored contents, `LEVEL` and pointers are unchanged.
- Full with pop in the same cycle: the push is accepted. `LEVEL` stays at `DEPTH` and `OVF` is not set.
- Empty with `VIN`: the frame is written; it is not forwarded combinationally.
- `CLR_OVF`=1 clears `OVF`. If a new overflow occurs in the same cycle, set wins.
- `VOUT`=1 with `OUT_RDY`=0: `DOUT`, `lidx` and the read pointer are held. `DOUT` must not change until the transfer.

## Timing
- Reset (asynchronous, `RST_N`=0): all of the following are 0 while reset is asserted and on release:
  - `DOUT`
  - `VOUT`
  - `LEVEL`
  - `OVF`
  - `DROP_CNT`
  - `lidx`
  - both pointers
  - the storage array
- Reset mid-frame discards every stored and partially emitted frame; output resumes only after a new push.
- Latency:
  - A push at edge n into an empty FIFO gives `VOUT`=1 with lane 0 during the cycle after edge n.
  - With `OUT_RDY` held at 1, lanes 1..`LANES-1` follow on consecutive cycles.
- Throughput: at most one sample per cycle on the output and one frame per cycle on the input. Sustained input must therefore average at most 1/`LANES` frame per cycle, or overflow occurs.
- All outputs are registered or decoded from registers. There is no combinational path from `DIN`/`VIN` to `DOUT`/`VOUT`. `OUT_RDY` affects state only.

## Configuration
- `FIR_P2S_DROPCNT_EN` defined:
  - Adds output `DROP_CNT`, which increments on every discarded frame.
  - It saturates at 255 and is cleared by `CLR_OVF`. An increment in the same cycle as `CLR_OVF` gives 1.
- `FIR_P2S_DROPCNT_EN` undefined: port and counter are absent; only `OVF` reports loss.

## Test plan
Defaults `NB`=8, `LANES`=3, `DEPTH`=4 in every scenario.
1. Single frame, lanes (0x01, 0x02, 0x03), `OUT_RDY`=1 → `VOUT`=1 for exactly 3 cycles starting the cycle after push. `DOUT`=0x01, 0x02, 0x03 in order. `LEVEL` goes 1, 1, 1, then 0.
2. Backpressure: same frame, `OUT_RDY`=0 for 5 cycles after lane 0 appears → `DOUT`=0x01 held for 5 cycles. After `OUT_RDY`=1, 0x02 then 0x03 follow; no sample is lost or duplicated.
3. Overflow: `OUT_RDY`=0, push 5 frames (0x10.., 0x20.., 0x30.., 0x40.., 0x50..) → `LEVEL`=4, `OVF`=1, `DROP_CNT`=1. Draining yields 12 samples from frames 0x10–0x40 only. `CLR_OVF` pulse → `OVF`=0, `DROP_CNT`=0.
4. Simultaneous push/pop at full: `LEVEL`=4, `lidx`=2, `OUT_RDY`=1, `VIN`=1 → `LEVEL` stays 4, `OVF`=0. The new frame is emitted last, in order.
5. Streaming: `VIN` every 3rd cycle, `OUT_RDY`=1, 100 frames → continuous `VOUT`=1 after start, `LEVEL` ≤ 1, output equals the input lanes in time order, `OVF`=0.
6. Reset mid-frame: assert `RST_N`=0 after lane 1 of a stored frame → `VOUT`, `DOUT`, `LEVEL` = 0 immediately (asynchronously). The next push emits its lane 0 first.
